// File: rtl/demux_pkg.sv
// Shared types for the 1-to-4 demux and its downstream gather stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package demux_pkg;

   localparam int NUM_LANES = 4;

   typedef logic [1:0] lane_sel_t;

   typedef enum logic {FILL, FULL} gather_state_t;

endpackage

// File: rtl/demux_gather_4.sv
// Collects four demuxed lane values (one per accepted beat) into one packed 4-lane word.
// Latency: out_valid rises the cycle after the fourth distinct lane is accepted; one beat/cycle sustained.
// Backpressure: while a full word waits, in_ready follows out_ready; a handoff may accept the next word's first beat.
//
// Ports:
//   clock, reset          : single clock, synchronous active-high reset
//   in_lanes/in_sel       : demux bundle and the select that produced it (only lane in_sel is used)
//   in_valid/in_ready     : input beat handshake
//   out_data/out_valid    : gathered word (lane k at out_data[k]) and its valid
//   out_ready             : consumer takes the word when out_valid && out_ready
//   dup_err               : sticky flag, a lane was written twice within one word
//   words_done            : count of handed-off words, wraps
module demux_gather_4
   import demux_pkg::*;
#(
   parameter int ID    = 1,
   parameter int WIDTH = 2,
   parameter int CNT_W = 16
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic [NUM_LANES-1:0][WIDTH-1:0]     in_lanes,
   input  lane_sel_t                           in_sel,
   input  logic                                in_valid,
   output logic                                in_ready,
   output logic [NUM_LANES-1:0][WIDTH-1:0]     out_data,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic                                dup_err,
   output logic [CNT_W-1:0]                    words_done
);

   // Instance identifier carries no function; only sanity-checked at elaboration.
   if (ID < 0) begin : g_id_chk
      $error("demux_gather_4: ID must be non-negative");
   end

   gather_state_t                     state, state_nxt;
   logic [NUM_LANES-1:0]              mask, mask_nxt;
   logic [NUM_LANES-1:0][WIDTH-1:0]   data;
   logic [NUM_LANES-1:0]              sel_oh;
   logic                              accept;
   logic                              handoff;
   logic                              dup_set;

   // in_ready depends only on state and out_ready, never on in_valid.
   assign in_ready  = (state == FILL) | out_ready;
   assign out_valid = (state == FULL);
   assign out_data  = data;

   assign accept  = in_valid & in_ready;
   assign handoff = (state == FULL) & out_ready;
   assign sel_oh  = NUM_LANES'(1) << in_sel;

   always_comb begin
      state_nxt = state;
      mask_nxt  = mask;
      dup_set   = 1'b0;
      case (state)
         FILL: begin
            if (accept) begin
               mask_nxt = mask | sel_oh;
               dup_set  = |(mask & sel_oh);
               if (&mask_nxt) begin
                  state_nxt = FULL;
               end
            end
         end
         FULL: begin
            if (handoff) begin
               state_nxt = FILL;
               // A beat accepted in the handoff cycle opens the next word.
               mask_nxt  = accept ? sel_oh : '0;
            end
         end
         default: begin
            state_nxt = FILL;
            mask_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= FILL;
         mask       <= '0;
         data       <= '0;
         dup_err    <= 1'b0;
         words_done <= '0;
      end else begin
         state <= state_nxt;
         mask  <= mask_nxt;
         if (dup_set) begin
            dup_err <= 1'b1;
         end
         // In FULL an accept can only happen together with the handoff,
         // so the presented word is never disturbed while it waits.
         if (accept) begin
            data[in_sel] <= in_lanes[in_sel];
         end
         if (handoff) begin
            words_done <= words_done + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_demux_gather_4.sv
module tb_demux_gather_4;

   localparam int W  = 8;
   localparam int CW = 2;

   logic                clock = 1'b0;
   logic                reset;
   logic [3:0][W-1:0]   in_lanes;
   logic [1:0]          in_sel;
   logic                in_valid;
   logic                in_ready;
   logic [3:0][W-1:0]   out_data;
   logic                out_valid;
   logic                out_ready;
   logic                dup_err;
   logic [CW-1:0]       words_done;

   int checks   = 0;
   int failures = 0;

   // Reference model: which lanes of the word under construction are known,
   // their values, whether a complete word is waiting, and how many words left.
   logic [3:0][W-1:0]   m_data;
   bit   [3:0]          m_have;
   bit                  m_full;
   bit                  m_dup;
   int                  m_cnt;

   demux_gather_4 #(.ID(1), .WIDTH(W), .CNT_W(CW)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_lanes   (in_lanes),
      .in_sel     (in_sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .dup_err    (dup_err),
      .words_done (words_done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_data = '0;
      m_have = '0;
      m_full = 1'b0;
      m_dup  = 1'b0;
      m_cnt  = 0;
   endtask

   task automatic check_outputs();
      chk("in_ready",   64'(in_ready),   64'(!m_full || out_ready));
      chk("out_valid",  64'(out_valid),  64'(m_full));
      chk("out_data",   64'(out_data),   64'(m_data));
      chk("dup_err",    64'(dup_err),    64'(m_dup));
      chk("words_done", 64'(words_done), 64'(m_cnt % (1 << CW)));
   endtask

   // One clock cycle: drive inputs, check outputs against the model, clock, update model.
   // Non-selected lanes carry random garbage that must be ignored.
   task automatic step(input bit v, input int sel, input logic [W-1:0] val, input bit rdy);
      logic [3:0][W-1:0] lanes;
      bit acc, hand;
      lanes       = $urandom;
      lanes[sel]  = val;
      in_valid    = v;
      in_sel      = sel[1:0];
      in_lanes    = lanes;
      out_ready   = rdy;
      #1;
      check_outputs();
      @(posedge clock);
      acc  = v && (!m_full || rdy);
      hand = m_full && rdy;
      if (hand) begin
         m_cnt++;
         m_have = '0;
         m_full = 1'b0;
      end
      if (acc) begin
         if (m_have[sel]) m_dup = 1'b1;
         m_data[sel] = val;
         m_have[sel] = 1'b1;
         if (m_have == 4'hF) m_full = 1'b1;
      end
      @(negedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      @(posedge clock);
      @(negedge clock);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_sel    = '0;
      in_lanes  = '0;
      out_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clock);
      @(negedge clock);
      #1;
      reset = 1'b0;

      // Reset state
      chk("rst_out_valid",  64'(out_valid),  64'd0);
      chk("rst_out_data",   64'(out_data),   64'd0);
      chk("rst_dup_err",    64'(dup_err),    64'd0);
      chk("rst_words_done", 64'(words_done), 64'd0);
      chk("rst_in_ready",   64'(in_ready),   64'd1);

      // Sequential fill
      step(1, 0, 8'h11, 1);
      step(1, 1, 8'h22, 1);
      step(1, 2, 8'h33, 1);
      chk("seq_not_yet", 64'(out_valid), 64'd0);
      step(1, 3, 8'h44, 1);
      chk("seq_valid", 64'(out_valid), 64'd1);
      chk("seq_data",  64'(out_data),  64'h44332211);
      step(0, 0, 8'h00, 1);
      chk("seq_words", 64'(words_done), 64'd1);
      chk("seq_dup",   64'(dup_err),    64'd0);

      // Out-of-order fill
      step(1, 2, 8'hA2, 1);
      step(1, 0, 8'hA0, 1);
      step(1, 3, 8'hA3, 1);
      step(1, 1, 8'hA1, 1);
      chk("ooo_data", 64'(out_data), 64'hA3A2A1A0);
      step(0, 0, 8'h00, 1);

      // Duplicate write
      do_reset();
      step(1, 0, 8'h01, 1);
      chk("dup_first", 64'(dup_err), 64'd0);
      step(1, 0, 8'h02, 1);
      chk("dup_second", 64'(dup_err), 64'd1);
      step(1, 1, 8'h11, 1);
      step(1, 2, 8'h12, 1);
      step(1, 3, 8'h13, 1);
      chk("dup_valid", 64'(out_valid), 64'd1);
      chk("dup_lane0", 64'(out_data[0]), 64'h02);
      step(0, 0, 8'h00, 1);
      chk("dup_sticky", 64'(dup_err), 64'd1);

      // Backpressure
      do_reset();
      step(1, 0, 8'hB0, 0);
      step(1, 1, 8'hB1, 0);
      step(1, 2, 8'hB2, 0);
      step(1, 3, 8'hB3, 0);
      for (int i = 0; i < 5; i++) begin
         step(1, int'($urandom_range(0, 3)), 8'($urandom), 0);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_data",     64'(out_data), 64'hB3B2B1B0);
      end
      step(1, 3, 8'h5C, 1);
      chk("bp_words", 64'(words_done), 64'd1);
      chk("bp_valid_drop", 64'(out_valid), 64'd0);
      step(1, 0, 8'hC0, 1);
      step(1, 1, 8'hC1, 1);
      step(1, 2, 8'hC2, 1);
      chk("bp_next_valid", 64'(out_valid), 64'd1);
      chk("bp_next_data",  64'(out_data),  64'h5CC2C1C0);
      chk("bp_no_dup",     64'(dup_err),   64'd0);
      step(0, 0, 8'h00, 1);

      // Reset mid-word
      do_reset();
      step(1, 0, 8'hEE, 1);
      step(1, 1, 8'hEF, 1);
      do_reset();
      step(1, 0, 8'hD0, 1);
      step(1, 1, 8'hD1, 1);
      step(1, 2, 8'hD2, 1);
      step(1, 3, 8'hD3, 1);
      chk("rmw_data", 64'(out_data), 64'hD3D2D1D0);
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 1);
      chk("rmw_words", 64'(words_done), 64'd1);

      // Counter wrap: five back-to-back words, handoff overlapping the next beat
      do_reset();
      for (int w = 0; w < 5; w++) begin
         for (int s = 0; s < 4; s++) begin
            step(1, s, 8'(w * 16 + s), 1);
         end
      end
      step(0, 0, 8'h00, 1);
      chk("wrap_words", 64'(words_done), 64'd1);
      chk("wrap_dup",   64'(dup_err),    64'd0);

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), 8'($urandom),
              $urandom_range(0, 2) != 0);
      end
      step(0, 0, 8'h00, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/demux_gather_4.md
# demux_gather_4

Downstream collector for the 1-to-4 demultiplexer in the openhls IP core set. Each accepted beat carries the demux's four-lane output bundle plus the select that produced it. The block latches the selected lane into a per-lane holding register. Once all four lanes hold fresh data, it presents them as one packed 4-lane word behind a valid/ready handshake, so a consumer can reassemble four sequentially demuxed values into a single parallel word.

## Interface
Parameters:
- ID, 1, instance identifier; no functional effect.
- WIDTH, 2, bits per lane; must match the upstream demux.
- CNT_W, 16, width of the completed-word counter.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_lanes  input  [3:0][WIDTH-1:0]  demux output bundle; only lane in_sel is meaningful.
- in_sel  input  2  lane select that produced in_lanes.
- in_valid  input  1  beat present.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- out_data  output  [3:0][WIDTH-1:0]  gathered word; lane k sits at out_data[k].
- out_valid  output  1  gathered word available.
- out_ready  input  1  consumer takes the word when out_valid && out_ready.
- dup_err  output  1  sticky; a lane was written twice within one word.
- words_done  output  CNT_W  count of words handed off; wraps modulo 2^CNT_W.

## Operation
- Internal state:
  - lane registers data[3:0], 4-bit fill mask, state FILL/FULL.
- FILL (the reset state):
  - in_ready = 1.
  - On accept, data[in_sel] <= in_lanes[in_sel] and mask[in_sel] <= 1.
  - If mask[in_sel] was already 1, the lane is overwritten (last write wins) and dup_err sets.
  - When the accept makes the mask 4'hF: go to FULL and assert out_valid next cycle.
- FULL:
  - out_valid = 1 and out_data = data; both are stable until handoff.
  - in_ready = out_ready, so input is stalled while the consumer stalls.
  - Handoff (out_valid && out_ready): mask <= 0 and words_done increments.
  - Without a simultaneous accept, go to FILL.
- Handoff and accept in the same cycle:
  - mask <= one-hot(in_sel); the new lane is written into data; state goes to FILL.
  - That beat is never dropped or counted as a duplicate.
- Lanes other than in_sel are ignored, even if nonzero.
- dup_err clears only on reset.
- Reset values: out_valid 0, out_data 0, mask 0, dup_err 0, words_done 0, state FILL.
- in_ready = 1 in the first cycle after reset.
- Reset asserted mid-word discards the partial word with no output.

## Timing
- Latency: out_valid rises the cycle after the fourth distinct lane is accepted.
- Throughput: one beat per cycle sustained. With out_ready held high, a word completes every 4 accepted beats with zero bubbles.
- No combinational path from in_valid to out_valid.
- in_ready depends combinationally only on state and out_ready.
- out_data is registered and changes only on lane writes. In FULL no lane is written until the handoff cycle.
- words_done updates the cycle after a handoff.

## Structure
- Shared package demux_pkg holds:
  - localparam NUM_LANES = 4;
  - typedef logic [1:0] lane_sel_t;
  - typedef enum logic {FILL, FULL} gather_state_t.
- The upstream demux should later import the same package.
- No sub-module; one flat module.

## Test plan
- Sequential fill: WIDTH=8; accept sel 0..3 with data 8'h11, 22, 33, 44 on consecutive cycles, out_ready=1. Required: out_valid one cycle after the 4th beat, out_data={44,33,22,11}, words_done=1, dup_err=0.
- Out-of-order fill: sel 2,0,3,1 with 8'hA2, A0, A3, A1. Required: lane k = 8'hAk.
- Duplicate write: sel 0 (8'h01), 0 (8'h02), 1, 2, 3. Required: dup_err=1 from the 2nd beat onward, lane 0 = 8'h02, word still emitted after the 5th beat.
- Backpressure: complete a word with out_ready=0 for 5 cycles while in_valid=1. Required: in_ready=0 and out_data stable for those 5 cycles. Raise out_ready alongside an in_sel=3 beat. Required: handoff in that cycle, mask=4'b1000 next.
- Reset mid-word: accept sel 0,1, then assert reset for 1 cycle, then fill 0..3. Required: exactly one word out, containing only post-reset data; words_done=1.
- Counter wrap: CNT_W=2, emit 5 words. Required: words_done reads 1 at the end.
